// File: rtl/s3_moore.sv
// Moore serial sequence detector. outp is high while the FSM holds a full
// match of PATTERN; the transition table is derived from PATTERN/OVERLAP.
module s3_moore #(
  parameter logic [2:0] PATTERN = 3'b101,
  parameter bit         OVERLAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inp,
  output logic       outp,
  output logic [1:0] state
);

  // Each encoding equals the number of pattern bits currently matched.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;

  // Longest prefix of PATTERN that is a suffix of (matched bits, bit_in).
  // The matched bits are always the top 'k' bits of PATTERN, so the window
  // is rebuilt from the state count alone.
  function automatic state_t next_state(input state_t cur, input logic bit_in);
    int k;
    int win;
    int pre;
    int mask;
    int best;
    k    = (cur == S3 && OVERLAP == 1'b0) ? 0 : int'(cur);
    win  = ((int'(PATTERN) >> (3 - k)) << 1) | int'(bit_in);
    best = 0;
    for (int len = 1; len <= 3; len++) begin
      if (len <= k + 1) begin
        pre  = int'(PATTERN) >> (3 - len);
        mask = (1 << len) - 1;
        if ((win & mask) == pre) best = len;
      end
    end
    return state_t'(2'(best));
  endfunction

  // NOTE: every always_comb target gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = S0;
    w_next = next_state(r_state, inp);
  end

  // NOTE: reset wins over the data path, so an unknown inp during reset
  // never reaches the state register; state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S0;
    else     r_state <= w_next;
  end

  assign state = r_state;
  assign outp  = (r_state == S3);

endmodule

// File: tb/tb_s3_moore.sv
// Self-checking bench: four detector configurations share one stimulus and
// are compared every cycle against a bit-history reference model.
module tb_s3_moore;

  localparam int N = 4;
  localparam logic [2:0] PAT [N] = '{3'b101, 3'b101, 3'b111, 3'b110};
  localparam bit         OVL [N] = '{1'b1,   1'b0,   1'b1,   1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inp = 1'b0;
  logic [1:0] st [N];
  logic       op [N];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: recent input bits and how many of them count.
  logic [2:0] hist_bits [N];
  int         hist_len  [N];
  int         exp_st    [N];

  s3_moore #(.PATTERN(3'b101), .OVERLAP(1'b1)) u_p101_ovl (
    .clk(clk), .rst(rst), .inp(inp), .outp(op[0]), .state(st[0]));
  s3_moore #(.PATTERN(3'b101), .OVERLAP(1'b0)) u_p101_novl (
    .clk(clk), .rst(rst), .inp(inp), .outp(op[1]), .state(st[1]));
  s3_moore #(.PATTERN(3'b111), .OVERLAP(1'b1)) u_p111_ovl (
    .clk(clk), .rst(rst), .inp(inp), .outp(op[2]), .state(st[2]));
  s3_moore #(.PATTERN(3'b110), .OVERLAP(1'b0)) u_p110_novl (
    .clk(clk), .rst(rst), .inp(inp), .outp(op[3]), .state(st[3]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Longest L (<= available history) where the last L bits equal the first
  // L bits of the pattern.
  function automatic int model_len(input logic [2:0] pat, input logic [2:0] bits,
                                   input int n);
    int best;
    int mask;
    best = 0;
    for (int l = 1; l <= 3; l++) begin
      mask = (1 << l) - 1;
      if (l <= n && (int'(bits) & mask) == (int'(pat) >> (3 - l))) best = l;
    end
    return best;
  endfunction

  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    inp = b;
    @(posedge clk);
    for (int m = 0; m < N; m++) begin
      if (r) begin
        hist_len[m]  = 0;
        hist_bits[m] = '0;
        exp_st[m]    = 0;
      end else begin
        hist_bits[m] = {hist_bits[m][1:0], b};
        hist_len[m]  = (hist_len[m] < 3) ? hist_len[m] + 1 : 3;
        exp_st[m]    = model_len(PAT[m], hist_bits[m], hist_len[m]);
        // Non-overlapping: a completed match forgets all earlier bits.
        if (!OVL[m] && exp_st[m] == 3) hist_len[m] = 0;
      end
    end
    #1;
    for (int m = 0; m < N; m++) begin
      check($sformatf("state[%0d]", m), int'(st[m]), exp_st[m]);
      check($sformatf("outp[%0d]", m), int'(op[m]), (exp_st[m] == 3) ? 1 : 0);
    end
  endtask

  initial begin
    logic [7:0] stream;
    int         tbl_ovl  [8] = '{1, 2, 3, 2, 3, 1, 2, 0};
    int         tbl_novl [8] = '{1, 2, 3, 0, 1, 1, 2, 0};

    for (int m = 0; m < N; m++) begin
      hist_bits[m] = '0;
      hist_len[m]  = 0;
      exp_st[m]    = 0;
    end

    // Held reset with inp=1: everything stays in S0.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

    // Reference stream 1,0,1,0,1,1,0,0 against the published state tables.
    stream = 8'b1010_1100;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, stream[7 - i]);
      check($sformatf("tbl_ovl[%0d]", i), int'(st[0]), tbl_ovl[i]);
      check($sformatf("tbl_novl[%0d]", i), int'(st[1]), tbl_novl[i]);
    end

    // Reach S3, reset with inp=1, then detect again.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    check("pre_rst_outp", int'(op[0]), 1);
    step(1'b1, 1'b1);
    check("rst_drop_outp", int'(op[0]), 0);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    check("redetect_outp", int'(op[0]), 1);

    // Long runs of zeros then ones; the 111 detector saturates in S3.
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("zeros_state", int'(st[0]), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    check("ones_state", int'(st[0]), 1);
    check("ones_p111_outp", int'(op[2]), 1);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
